// File: rtl/gpio_in_sampler.sv
// Input-side GPIO datapath: pad synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
// mode-gated edge detection into a sticky write-1-to-clear status register and a level irq.
module gpio_in_sampler #(
  parameter int unsigned NUM_PINS        = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PINS-1:0]     pad_in,
  input  logic [2*NUM_PINS-1:0]   pin_mode,
  input  logic [NUM_PINS-1:0]     ier_rise,
  input  logic [NUM_PINS-1:0]     ier_fall,
  input  logic [NUM_PINS-1:0]     isr_clr,
  output logic [NUM_PINS-1:0]     pin_value,
  output logic [NUM_PINS-1:0]     isr,
  output logic                    irq
);

  localparam logic [1:0] IO_IN = 2'd0;

  logic [NUM_PINS-1:0] r_sync1;
  logic [NUM_PINS-1:0] r_sync2;
  logic [NUM_PINS-1:0] r_prev;
  logic [NUM_PINS-1:0] r_isr;
  logic [NUM_PINS-1:0] w_committed;
  logic [NUM_PINS-1:0] w_elig;
  logic [NUM_PINS-1:0] w_rise;
  logic [NUM_PINS-1:0] w_fall;
  logic [NUM_PINS-1:0] w_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pad_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]    r_cnt [NUM_PINS];
  logic [CNT_W-1:0]    w_cnt_d [NUM_PINS];
  logic [NUM_PINS-1:0] r_committed;
  logic [NUM_PINS-1:0] w_committed_d;

  // A pin commits only after sync2 has disagreed with the committed level for
  // DEBOUNCE_CYCLES consecutive cycles; any return to agreement restarts the count.
  always_comb begin
    w_committed_d = r_committed;
    for (int i = 0; i < NUM_PINS; i++) begin
      w_cnt_d[i] = '0;
      if (r_sync2[i] != r_committed[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_committed_d[i] = r_sync2[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_committed <= '0;
      for (int i = 0; i < NUM_PINS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_committed <= w_committed_d;
      for (int i = 0; i < NUM_PINS; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  assign w_committed = r_committed;
`else
  logic w_unused_debounce;

  assign w_unused_debounce = ^DEBOUNCE_CYCLES;
  assign w_committed       = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_committed;
    end
  end

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      w_elig[i] = (pin_mode[2*i +: 2] == IO_IN);
    end
  end

  assign w_rise = w_committed & ~r_prev;
  assign w_fall = ~w_committed & r_prev;
  assign w_evt  = w_elig & ((w_rise & ier_rise) | (w_fall & ier_fall));

  // Set has priority over clear so an edge coincident with a clear is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isr <= '0;
    end else begin
      r_isr <= w_evt | (r_isr & ~isr_clr);
    end
  end

  assign pin_value = w_committed;
  assign isr       = r_isr;
  assign irq       = |r_isr;

endmodule
